// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per functional unit and a
// round-robin pick of one buffered result per cycle onto registered CDB outputs.

module cdb_hold_buf #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              grant,
    input  logic [TAG_W-1:0]  new_tag,
    input  logic [DATA_W-1:0] new_value,
    output logic              held,
    output logic [TAG_W-1:0]  held_tag,
    output logic [DATA_W-1:0] held_value
);

    // A load on the granting edge wins, so a busy FU keeps full throughput.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            held <= 1'b0;
        else if (flush)
            held <= 1'b0;
        else if (load)
            held <= 1'b1;
        else if (grant)
            held <= 1'b0;
    end

    always_ff @(posedge clock) begin
        if (load) begin
            held_tag   <= new_tag;
            held_value <= new_value;
        end
    end

endmodule

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]             buf_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0] buf_value;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             accept;
    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               grant_idx;
    logic                           grant_any;
    logic [PTR_W:0]                 scan_sum;
    logic [PTR_W-1:0]               scan_idx;

    // Scan from rr_ptr upward with wraparound; first occupied buffer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_sum >= NREQ)
                scan_sum = scan_sum - NREQ;
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_any && buf_valid[scan_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // Ready comes from registered state only, never from req_valid.
    assign req_ready = ~buf_valid | grant;
    assign accept    = req_valid & req_ready & {NUM_REQ{~flush}};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        cdb_hold_buf #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_buf (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .load       (accept[i]),
            .grant      (grant[i]),
            .new_tag    (req_tag[i*TAG_W +: TAG_W]),
            .new_value  (req_value[i*DATA_W +: DATA_W]),
            .held       (buf_valid[i]),
            .held_tag   (buf_tag[i]),
            .held_value (buf_value[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= buf_tag[grant_idx];
            cdb_value <= buf_value[grant_idx];
            rr_ptr    <= (grant_idx == LAST) ? '0 : grant_idx + PTR_W'(1);
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, fairness,
// flush and back-to-back streaming, each with hand-computed expectations.

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*TW-1:0]   req_tag = '0;
    logic [N*DW-1:0]   req_value = '0;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_value;

    int checks = 0;
    int passed = 0;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_tag[i*TW +: TW]    = t;
        req_value[i*DW +: DW]  = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", cdb_valid); else passed++;
        checks++; if (cdb_tag !== 5'd0) $display("FAIL reset_tag got %h want 0", cdb_tag); else passed++;
        checks++; if (cdb_value !== 32'd0) $display("FAIL reset_value got %h want 0", cdb_value); else passed++;
        checks++; if (req_ready !== 4'hF) $display("FAIL reset_ready got %b want 1111", req_ready); else passed++;
        reset = 1'b0;
        drive(0, 1'b1, 5'd9, 32'h9);
        drive(1, 1'b1, 5'd10, 32'hA);
        tick;
        drive(0, 1'b0, 5'd0, 32'h0);
        drive(1, 1'b0, 5'd0, 32'h0);
        checks++; if (req_ready !== 4'b1101) $display("FAIL preload_ready got %b want 1101", req_ready); else passed++;
        tick;
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd9) $display("FAIL preload_bcast got v=%b t=%0d want v=1 t=9", cdb_valid, cdb_tag); else passed++;
        // Reset in the middle of the high phase, no clock edge involved.
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cdb_valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", cdb_valid); else passed++;
        checks++; if (cdb_tag !== 5'd0) $display("FAIL midreset_tag got %h want 0", cdb_tag); else passed++;
        checks++; if (cdb_value !== 32'd0) $display("FAIL midreset_value got %h want 0", cdb_value); else passed++;
        checks++; if (req_ready !== 4'hF) $display("FAIL midreset_ready got %b want 1111", req_ready); else passed++;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++; if (cdb_valid !== 1'b0) $display("FAIL postreset_drop%0d got %b want 0", c, cdb_valid); else passed++;
        end
    endtask

    task automatic test_single;
        do_reset;
        drive(1, 1'b1, 5'd1, 32'h123);
        tick;
        drive(1, 1'b0, 5'd0, 32'h0);
        checks++; if (cdb_valid !== 1'b0) $display("FAIL single_edge1 got %b want 0", cdb_valid); else passed++;
        tick;
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd1 || cdb_value !== 32'h123)
            $display("FAIL single_bcast got v=%b t=%0d d=%h want v=1 t=1 d=123", cdb_valid, cdb_tag, cdb_value); else passed++;
        tick;
        checks++; if (cdb_valid !== 1'b0) $display("FAIL single_once got %b want 0", cdb_valid); else passed++;
        checks++; if (cdb_tag !== 5'd1 || cdb_value !== 32'h123)
            $display("FAIL single_hold got t=%0d d=%h want t=1 d=123", cdb_tag, cdb_value); else passed++;
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_rdy [3];
        exp_rdy = '{4'b0011, 4'b0111, 4'b1111};
        do_reset;
        for (int i = 0; i < N; i++) drive(i, 1'b1, TW'(i + 1), 32'hA000 + DW'(i + 1));
        tick;
        for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'h0);
        checks++; if (req_ready !== 4'b0001) $display("FAIL cont_ready0 got %b want 0001", req_ready); else passed++;
        for (int k = 0; k < N; k++) begin
            tick;
            checks++; if (cdb_valid !== 1'b1 || cdb_tag !== TW'(k + 1) || cdb_value !== 32'hA000 + DW'(k + 1))
                $display("FAIL cont_bcast%0d got v=%b t=%0d d=%h want v=1 t=%0d", k, cdb_valid, cdb_tag, cdb_value, k + 1); else passed++;
            if (k < 3) begin
                checks++; if (req_ready !== exp_rdy[k]) $display("FAIL cont_ready%0d got %b want %b", k + 1, req_ready, exp_rdy[k]); else passed++;
            end
        end
        tick;
        checks++; if (cdb_valid !== 1'b0) $display("FAIL cont_idle got %b want 0", cdb_valid); else passed++;
    endtask

    task automatic test_fairness;
        logic          exp_v [7];
        logic [TW-1:0] exp_t [7];
        int            idx;
        logic          r0, r2;
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t = '{5'd0, 5'd8, 5'd7, 5'd9, 5'd10, 5'd11, 5'd0};
        idx = 0;
        drive(0, 1'b1, 5'd8, 32'hB008);
        drive(2, 1'b1, 5'd7, 32'hB007);
        for (int c = 0; c < 7; c++) begin
            r0 = req_ready[0];
            r2 = req_ready[2];
            tick;
            if (req_valid[0] && r0) idx++;
            if (req_valid[2] && r2) drive(2, 1'b0, 5'd0, 32'h0);
            if (idx < 4) drive(0, 1'b1, TW'(8 + idx), 32'hB000 + DW'(8 + idx));
            else drive(0, 1'b0, 5'd0, 32'h0);
            checks++;
            if (cdb_valid !== exp_v[c] || (exp_v[c] && (cdb_tag !== exp_t[c] || cdb_value !== 32'hB000 + DW'(exp_t[c]))))
                $display("FAIL fair_cyc%0d got v=%b t=%0d d=%h want v=%b t=%0d", c, cdb_valid, cdb_tag, cdb_value, exp_v[c], exp_t[c]);
            else passed++;
        end
        checks++; if (idx !== 4) $display("FAIL fair_accepts got %0d want 4", idx); else passed++;
    endtask

    task automatic test_flush;
        drive(1, 1'b1, 5'd3, 32'hC003);
        drive(3, 1'b1, 5'd4, 32'hC004);
        tick;
        drive(1, 1'b0, 5'd0, 32'h0);
        drive(3, 1'b0, 5'd0, 32'h0);
        checks++; if (req_ready !== 4'b0111) $display("FAIL flush_pre_ready got %b want 0111", req_ready); else passed++;
        flush = 1'b1;
        drive(0, 1'b1, 5'd30, 32'hC01E);
        tick;
        flush = 1'b0;
        drive(0, 1'b0, 5'd0, 32'h0);
        checks++; if (cdb_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", cdb_valid); else passed++;
        checks++; if (req_ready !== 4'hF) $display("FAIL flush_ready got %b want 1111", req_ready); else passed++;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd11)
                $display("FAIL flush_squash%0d got v=%b t=%0d want v=0 t=11", c, cdb_valid, cdb_tag); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int   idx;
        logic r3;
        idx = 0;
        drive(3, 1'b1, 5'd20, 32'hD014);
        for (int c = 0; c < 6; c++) begin
            r3 = req_ready[3];
            tick;
            if (req_valid[3] && r3) idx++;
            if (idx < 4) drive(3, 1'b1, TW'(20 + idx), 32'hD000 + DW'(20 + idx));
            else drive(3, 1'b0, 5'd0, 32'h0);
            checks++; if (req_ready[3] !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", c, req_ready[3]); else passed++;
            if (c >= 1 && c <= 4) begin
                checks++; if (cdb_valid !== 1'b1 || cdb_tag !== TW'(19 + c) || cdb_value !== 32'hD000 + DW'(19 + c))
                    $display("FAIL b2b_bcast%0d got v=%b t=%0d d=%h want v=1 t=%0d", c, cdb_valid, cdb_tag, cdb_value, 19 + c); else passed++;
            end else begin
                checks++; if (cdb_valid !== 1'b0) $display("FAIL b2b_idle%0d got %b want 0", c, cdb_valid); else passed++;
            end
        end
        checks++; if (idx !== 4) $display("FAIL b2b_accepts got %0d want 4", idx); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_flush;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
